// File: rtl/register_bank_arbiter_pkg.sv
// Shared constants and helpers for the round-robin register bank writer.
package regbank_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned ADDR_W    = $clog2(DEPTH_DEF);
  localparam int unsigned ID_W      = $clog2(N_REQ_DEF);

  // Widest one-hot the helper can produce; callers truncate to their own width.
  localparam int unsigned OH_MAX = 256;

  function automatic logic [OH_MAX-1:0] onehot(input int unsigned idx);
    logic [OH_MAX-1:0] v;
    v = '0;
    v[idx[7:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/register_bank_arbiter_if.sv
// Requester-side write bus plus the combinational read/observe port.
interface register_bank_arbiter_if
  import regbank_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  localparam int unsigned A_W = $clog2(DEPTH);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*A_W-1:0]   wr_addr;
  logic [N_REQ*WIDTH-1:0] wr_data;
  logic [N_REQ-1:0]       gnt;
  logic [A_W-1:0]         rd_addr;
  logic [WIDTH-1:0]       rd_data;
  logic [DEPTH-1:0]       load;

  modport master (
    output req, wr_addr, wr_data, rd_addr,
    input  gnt, rd_data, load
  );

  modport slave (
    input  req, wr_addr, wr_data, rd_addr,
    output gnt, rd_data, load
  );

endinterface

// File: rtl/register_bank_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after i_ptr, wrapping.
module rr_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_elig,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_onehot,
  output logic [ID_W-1:0] o_idx,
  output logic            o_valid
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_cand;

  // Scan from farthest to nearest so the nearest eligible index is kept last.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N)) begin
        w_sum = w_sum - (ID_W+1)'(N);
      end
      w_cand = w_sum[ID_W-1:0];
      if (i_elig[w_cand]) begin
        o_onehot         = '0;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
        o_valid          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_bank_arbiter.sv
// Register bank with one write port shared round-robin among N_REQ requesters.
module register_bank_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  register_bank_arbiter_if.slave  bus
);

  localparam int unsigned A_W = $clog2(DEPTH);
  localparam int unsigned I_W = $clog2(N_REQ);

  logic [WIDTH-1:0] r_bank [DEPTH];
  logic [N_REQ-1:0] r_gnt;
  logic [I_W-1:0]   r_ptr;

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_win_oh;
  logic [I_W-1:0]   w_win_idx;
  logic             w_win_valid;
  logic [A_W-1:0]   w_win_addr;
  logic [WIDTH-1:0] w_win_data;
  logic [DEPTH-1:0] w_load;
  logic [I_W-1:0]   w_ptr_nxt;

  // A requester seeing its grant this cycle is masked so a held req cannot double-write.
  assign w_elig = bus.req & ~r_gnt;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (I_W)
  ) u_rr_arbiter (
    .i_elig   (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_valid)
  );

  assign w_win_addr = bus.wr_addr[w_win_idx*A_W +: A_W];
  assign w_win_data = bus.wr_data[w_win_idx*WIDTH +: WIDTH];

  always_comb begin
    w_load = '0;
    if (rst_n && w_win_valid) begin
      w_load = DEPTH'(onehot(32'(w_win_addr)));
    end
  end

  assign w_ptr_nxt = (w_win_idx == I_W'(N_REQ - 1)) ? '0 : w_win_idx + I_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= '0;
      r_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      r_gnt <= w_win_valid ? w_win_oh : '0;
      if (w_win_valid) begin
        r_ptr <= w_ptr_nxt;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_load[i]) begin
          r_bank[i] <= w_win_data;
        end
      end
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.load    = w_load;
  assign bus.rd_data = r_bank[bus.rd_addr];

endmodule

// File: tb/tb_register_bank_arbiter.sv
// Directed checks of grant order, masking, wrap, withdrawal and async reset.
module tb_register_bank_arbiter;
  import regbank_pkg::*;

  localparam int unsigned NR = N_REQ_DEF;
  localparam int unsigned DP = DEPTH_DEF;
  localparam int unsigned WD = WIDTH_DEF;
  localparam int unsigned AW = ADDR_W;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [ID_W-1:0] order [5];

  always #10 clk = ~clk;

  register_bank_arbiter_if #(.N_REQ(NR), .DEPTH(DP), .WIDTH(WD)) bif ();

  register_bank_arbiter #(.N_REQ(NR), .DEPTH(DP), .WIDTH(WD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] oh(input int n);
    return 32'(1) << n;
  endfunction

  task automatic set_req(input int i, input logic on, input logic [AW-1:0] a, input logic [WD-1:0] d);
    bif.req[i] = on;
    bif.wr_addr[i*AW +: AW] = a;
    bif.wr_data[i*WD +: WD] = d;
  endtask

  task automatic read_chk(input string tag, input int a, input logic [WD-1:0] exp);
    bif.rd_addr = AW'(a);
    #1;
    check(tag, 32'(bif.rd_data), 32'(exp));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    bif.req     = '0;
    bif.wr_addr = '0;
    bif.wr_data = '0;
    bif.rd_addr = '0;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

    // Reset state
    #3;
    for (int a = 0; a < int'(DP); a++) read_chk($sformatf("rst_rd%0d", a), a, '0);
    check("rst_gnt", 32'(bif.gnt), 32'(0));
    check("rst_load", 32'(bif.load), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("idle_gnt%0d", k), 32'(bif.gnt), 32'(0));
    end
    read_chk("idle_rd3", 3, '0);

    // Single write, then held req is masked during its grant cycle
    set_req(2, 1'b1, AW'(3), 16'hBEEF);
    #1;
    check("sw_load", 32'(bif.load), oh(3));
    cyc();
    check("sw_gnt", 32'(bif.gnt), 32'(4'b0100));
    read_chk("sw_rd", 3, 16'hBEEF);
    check("sw_masked_load", 32'(bif.load), 32'(0));
    cyc();
    check("sw_no_regrant", 32'(bif.gnt), 32'(0));
    bif.req = '0;

    // Round robin from ptr 0 with all four requesting
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    read_chk("rr_cleared", 3, '0);
    for (int i = 0; i < int'(NR); i++) set_req(i, 1'b1, AW'(i), WD'(16'h1000 + i));
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_load%0d", k), 32'(bif.load), oh(int'(order[k])));
      cyc();
      check($sformatf("rr_gnt%0d", k), 32'(bif.gnt), oh(int'(order[k])));
    end
    bif.req = '0;
    for (int i = 0; i < int'(NR); i++) read_chk($sformatf("rr_reg%0d", i), i, WD'(16'h1000 + i));

    // Wrap after requester 3, then same-address contention on 5 (ptr now 1)
    set_req(3, 1'b1, AW'(6), 16'h3333);
    cyc();
    check("wr_gnt3", 32'(bif.gnt), 32'(4'b1000));
    set_req(3, 1'b0, AW'(6), 16'h3333);
    set_req(0, 1'b1, AW'(5), 16'hAAAA);
    set_req(1, 1'b1, AW'(5), 16'h5555);
    #1;
    check("wr_load0", 32'(bif.load), oh(5));
    cyc();
    check("wr_gnt0", 32'(bif.gnt), 32'(4'b0001));
    read_chk("wr_rd5a", 5, 16'hAAAA);
    set_req(0, 1'b0, AW'(5), 16'hAAAA);
    cyc();
    check("wr_gnt1", 32'(bif.gnt), 32'(4'b0010));
    bif.req = '0;
    read_chk("wr_rd5b", 5, 16'h5555);
    read_chk("wr_rd6", 6, 16'h3333);

    // Withdraw: req[1] raised alongside req[0] (ptr 2 -> 0 wins), dropped before its turn
    set_req(0, 1'b1, AW'(7), 16'h7777);
    set_req(1, 1'b1, AW'(4), 16'h4444);
    #1;
    check("wd_load", 32'(bif.load), oh(7));
    cyc();
    check("wd_gnt0", 32'(bif.gnt), 32'(4'b0001));
    bif.req = '0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("wd_nognt%0d", k), 32'(bif.gnt), 32'(0));
    end
    read_chk("wd_rd4", 4, '0);
    read_chk("wd_rd7", 7, 16'h7777);

    // Async reset mid-stream (ptr 1): grants 1 then 2, reset, then lowest active first
    for (int i = 1; i < int'(NR); i++) set_req(i, 1'b1, AW'(i), WD'(16'h2000 + i));
    cyc();
    check("mr_gnt1", 32'(bif.gnt), 32'(4'b0010));
    cyc();
    check("mr_gnt2", 32'(bif.gnt), 32'(4'b0100));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mr_rst_gnt", 32'(bif.gnt), 32'(0));
    check("mr_rst_load", 32'(bif.load), 32'(0));
    read_chk("mr_rst_rd1", 1, '0);
    read_chk("mr_rst_rd3", 3, '0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("mr_rel_gnt", 32'(bif.gnt), 32'(0));
    cyc();
    check("mr_first_gnt", 32'(bif.gnt), 32'(4'b0010));
    read_chk("mr_rd1", 1, 16'h2001);
    read_chk("mr_rd2", 2, '0);
    bif.req = '0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
